// File: rtl/branch_redirect_unit.sv
// Resolves EX-stage branches and jumps, owns the fetch PC, and raises the pipeline flush.
// It also keeps branch and taken-transfer event counters for performance debug.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_br_i,
  input  logic             ex_is_jal_i,
  input  logic             ex_is_jalr_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_imm_i,
  input  logic [31:0]      ex_rs1_i,
  input  logic             br_less_i,
  input  logic             br_equal_i,
  output logic             br_unsign_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             flush_o,
  output logic             taken_o,
  output logic             misalign_o,
  output logic             illegal_br_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  logic        is_jalr;
  logic        is_jal;
  logic        is_br;
  logic        br_illegal;
  logic        cond;
  logic        taken;
  logic        redirect;
  logic        misalign_now;
  logic [31:0] target;

  // Flag priority: JALR over JAL over conditional branch
  assign is_jalr    = ex_valid_i & ex_is_jalr_i;
  assign is_jal     = ex_valid_i & ex_is_jal_i & ~ex_is_jalr_i;
  assign is_br      = ex_valid_i & ex_is_br_i & ~ex_is_jal_i & ~ex_is_jalr_i;
  assign br_illegal = is_br & (ex_funct3_i[2:1] == 2'b01);

  assign br_unsign_o = ex_funct3_i[1];

  always_comb begin
    cond = 1'b0;
    case (ex_funct3_i)
      3'b000:  cond = br_equal_i;
      3'b001:  cond = ~br_equal_i;
      3'b100,
      3'b110:  cond = br_less_i;
      3'b101,
      3'b111:  cond = ~br_less_i;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    target = ex_pc_i + ex_imm_i;
    if (is_jalr) target = (ex_rs1_i + ex_imm_i) & ~32'h1;
  end

  assign taken        = is_jalr | is_jal | (is_br & cond);
  assign misalign_now = taken & target[1];
  assign redirect     = taken & ~target[1];

  assign taken_o    = taken;
  assign flush_o    = redirect;
  assign pc_plus4_o = pc_o + 32'd4;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o         <= RESET_PC;
      misalign_o   <= 1'b0;
      illegal_br_o <= 1'b0;
      br_cnt_o     <= '0;
      taken_cnt_o  <= '0;
    end else begin
      if (redirect)     pc_o <= target;
      else if (!stall_i) pc_o <= pc_plus4_o;
      misalign_o   <= misalign_now;
      illegal_br_o <= br_illegal;
      // Counters track resolved events, independent of fetch stalls
      if (is_br && !br_illegal) br_cnt_o <= br_cnt_o + CNT_W'(1);
      if (taken)                taken_cnt_o <= taken_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumes `br_less`/`br_equal` from the EX-stage branch comparator and decides whether a conditional branch, JAL or JALR is taken.
- Drives `br_unsign_o` back to the comparator.
- Owns the fetch program counter: computes and loads the redirect target, and raises the pipeline flush.
- Keeps branch/taken event counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the two performance counters.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hazard unit holds fetch PC.
- ex_valid_i  in  1  EX-stage instruction is valid (not a bubble).
- ex_is_br_i  in  1  EX instruction is a conditional branch.
- ex_is_jal_i  in  1  EX instruction is JAL.
- ex_is_jalr_i  in  1  EX instruction is JALR.
- ex_funct3_i  in  3  branch funct3.
- ex_pc_i  in  32  PC of EX instruction.
- ex_imm_i  in  32  sign-extended immediate.
- ex_rs1_i  in  32  rs1 operand (JALR base).
- br_less_i  in  1  comparator less result.
- br_equal_i  in  1  comparator equal result.
- br_unsign_o  out  1  to comparator: 1 = unsigned compare.
- pc_o  out  32  current fetch PC.
- pc_plus4_o  out  32  pc_o + 4.
- flush_o  out  1  squash IF/ID and ID/EX on next edge.
- taken_o  out  1  EX control transfer is taken this cycle.
- misalign_o  out  1  registered one-cycle pulse: taken target not word aligned.
- illegal_br_o  out  1  registered one-cycle pulse: funct3 010/011 on a branch.
- br_cnt_o  out  CNT_W  count of resolved conditional branches.
- taken_cnt_o  out  CNT_W  count of taken control transfers (incl. jumps).

Behaviour:
- Reset (async, immediate): pc_o=RESET_PC; misalign_o, illegal_br_o, br_cnt_o, taken_cnt_o = 0. Combinational outputs follow from these values.
- `br_unsign_o = ex_funct3_i[1]`, purely combinational, driven even when not a branch.
- Condition (only when ex_valid_i & ex_is_br_i):
  - 000: taken = equal
  - 001: taken = !equal
  - 100: taken = less
  - 101: taken = !less
  - 110: taken = less
  - 111: taken = !less
  - 010/011: not taken; illegal_br_o pulses next cycle.
- Jumps: JAL and JALR are always taken when ex_valid_i. Flag priority if multiple are set: JALR > JAL > branch.
- Target computation, all 32-bit with carry discarded (wraps at 2^32):
  - branch/JAL: ex_pc_i + ex_imm_i
  - JALR: (ex_rs1_i + ex_imm_i) & ~32'h1
- taken_o is combinational in the same cycle.
- Misalignment: if taken and target[1]=1:
  - no redirect, flush_o=0;
  - misalign_o pulses for exactly one cycle after the edge;
  - PC advances normally.
- Redirect:
  - redirect = taken & target aligned.
  - flush_o = redirect (combinational).
  - On the next edge pc_o <= target.
- PC update priority: redirect > stall_i (hold) > pc_o + 4. The PC wraps from 32'hFFFF_FFFC to 0.
- ex_valid_i=0: no taken, flush, counter or pulse activity, regardless of the other inputs.
- Counters:
  - br_cnt_o increments on every valid conditional branch with legal funct3.
  - taken_cnt_o increments on every taken transfer, including misaligned ones.
  - Both wrap modulo 2^CNT_W and are unaffected by stall_i.
- Reset asserted mid-redirect: PC returns to RESET_PC; pending pulses are cleared.
- Latency: decision and flush in cycle N; new PC visible at pc_o in cycle N+1.

Test Plan:
1. Reset release with RESET_PC=0, no stall, no EX activity → pc_o = 0, 4, 8, 12 on successive cycles; flush_o=0; counters 0.
2. BLT (funct3 100), ex_pc=0x100, imm=0xFFFFFFF0, less=1 → br_unsign_o=0, taken_o=1, flush_o=1. Next cycle pc_o=0xF0, br_cnt=1, taken_cnt=1.
3. BGEU (funct3 111), less=1, equal=0 → br_unsign_o=1, taken_o=0, flush_o=0; PC increments by 4; br_cnt increments, taken_cnt unchanged.
4. JALR with rs1=0x2001, imm=0x4 → target 0x2004 (bit0 cleared), redirect. Same cycle with stall_i=1 → redirect wins; pc_o=0x2004 next cycle.
5. Taken JAL, ex_pc=0x10, imm=0x6 → target 0x16: no flush; misalign_o=1 for one cycle; pc_o continues +4; taken_cnt increments.
6. Branch with funct3 010 and equal=1 → not taken; illegal_br_o single-cycle pulse; br_cnt unchanged. Then assert rst_i mid-cycle → all registered outputs clear immediately, pc_o=RESET_PC.
